mips32_pipe: RTL and testbench
==============================

# mips32_pipe

Five-stage in-order MIPS-style 32-bit processor core (IF, ID, EX, MEM, WB) with a unified word-addressed memory and a 32-entry register file. It is the top-level execution engine of the design. It is self-contained: programs and data are preloaded into internal arrays and results are read back from them. Stages alternate between two internal phases on one clock, so one instruction issues every two clock cycles. There is no forwarding and no interlocking.

## Interface
- No parameters. Fixed sizes: 32-bit datapath, 32 registers, 1024-word memory.
- clk1  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- No other ports. Bench-visible internal state, by exact name:
  - mem[0:1023] (32-bit): instructions and data.
  - Reg[0:31] (32-bit): register file.
  - PC (32-bit): fetch address.
  - HALTED (1-bit): halt flag.

## Operation
- Phase bit alternates every clock.
  - Phase A edges perform IF, EX and WB.
  - Phase B edges perform ID and MEM.
- Fields:
  - opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11].
  - imm = [15:0], sign-extended to 32 bits.
- R-type ops, rd <= rs op rt:
  - ADD 000000, SUB 000001, AND 000010, OR 000011.
  - SLT 000100: signed compare, result 1 or 0.
  - MUL 000101: low 32 bits of the product.
- I-type ALU ops, rt <= rs op imm: ADDI 001010, SUBI 001011, SLTI 001100.
- Memory ops:
  - LW 001000: rt <= mem[rs+imm].
  - SW 001001: mem[rs+imm] <= rt.
  - Address uses bits [9:0].
- Branches:
  - BNEQZ 001101 is taken if rs != 0.
  - BEQZ 001110 is taken if rs == 0.
  - Target = (branch address + 1) + imm.
- HLT 111111.
- Any other opcode is a no-op: no register or memory write.
- R0 is an ordinary writable register, not hardwired to zero.
- ID reads registers combinationally from Reg.
- Writes: only the WB stage writes Reg; only the MEM stage writes mem.
- Taken branch:
  - The IF edge that finds a taken branch in the EX/MEM latch fetches from the target, sets PC = target+1 and sets TAKEN_BRANCH.
  - The single instruction fetched behind the branch is squashed: its SW is suppressed at MEM and its register write is suppressed at WB.
  - TAKEN_BRANCH clears at that WB edge.
- HLT:
  - While HLT sits in IF/ID, IF fetches nothing and PC does not advance.
  - Older instructions drain normally.
  - HALTED is set at HLT's WB edge. After that all state (PC, Reg, mem, latches) is frozen until rst.
- Reset clears:
  - PC = 0, phase = A, HALTED = 0, TAKEN_BRANCH = 0.
  - All pipeline latches, IR = 0 and type = no-op.
- Reset does not clear Reg or mem.
- rst mid-operation aborts all in-flight instructions without commits at that edge.

## Timing
- First phase-A edge after rst deasserts is edge 0.
- Instruction i is fetched at edge 2i. Its stages fall on:
  - ID at 2i+1, EX at 2i+2, MEM at 2i+3, WB at 2i+4.
- A consumer at distance 2 reads the new value:
  - Instruction i+2 decodes at 2i+5, after i's WB at 2i+4.
  - The register file must not bypass.
- A consumer at distance 1 reads the stale value. This is required behaviour; software must space dependencies at least 2 apart.
- Branch at i:
  - The target is fetched at edge 2i+4.
  - Exactly one squashed slot (i+1) precedes it.
- LW result is available to an instruction 2 positions later, the same as for ALU ops.

## Test plan
- Factorial, with Reg[k]=k preloaded, mem[200]=7 and PC=0:
  - Program:
    - 0: ADDI R0,R0,200
    - 1: LW R1,200(R0)
    - 2: ADD R31,R31,R31
    - 3: SUBI R2,R1,1
    - 4: ADD R16,R16,R16
    - 5: MUL R1,R1,R2
    - 6: SUBI R2,R2,1
    - 7: ADD R31,R31,R31
    - 8: BNEQZ R2,-4
    - 9: SW R1,0(R0)
    - 10: HLT
  - Expected: mem[200]=5040, R1=5040, R2=0, R0=200, HALTED=1.
  - The LW address must use the old R0=0.
- Stale read:
  - Program: ADDI R5,R0,9 immediately followed by ADD R6,R5,R5, with R0=0 and R5=5.
  - Expected: R6=10 (stale); with one filler between them, R6=18.
- Branch squash:
  - Program: BEQZ R0,+2 (R0=0), then SW R7,100(R0), then ADDI R8,R0,1, then target ADDI R9,R0,3.
  - Expected: mem[100] unchanged, R8 unchanged, R9=3.
- ALU coverage:
  - Inputs: R1=-3, R2=5.
  - Expected: SUB=-8, AND=5, OR=-3, SLT R1,R2=1, SLTI R2,-1=0, MUL=-15.
- HLT freeze:
  - After HALTED=1, run 20 more clocks.
  - Expected: PC, Reg and mem unchanged; the instruction after HLT never commits.
- Reset:
  - Assert rst mid-loop for one edge.
  - Expected: PC=0, HALTED=0, no writes at that edge; execution restarts from mem[0].

Source files
------------

// File: rtl/mips32_pipe.sv
// mips32_pipe: five-stage MIPS-style core, one issue every two clocks.
// IF/EX/WB run on phase A edges, ID/MEM on phase B edges; no forwarding.
module mips32_pipe (
  input logic clk1,
  input logic rst
);
  typedef enum logic [2:0] {
    T_RR, T_RM, T_LD, T_ST, T_BR, T_HLT, T_NOP
  } itype_e;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  logic [31:0] mem [0:1023];
  logic [31:0] Reg [0:31];
  logic [31:0] PC, pc_d;
  logic        HALTED, halted_d;
  logic        phase_q, phase_d;
  logic        taken_q, taken_d;

  logic [31:0] if_id_ir_q, if_id_ir_d;
  logic [31:0] if_id_npc_q, if_id_npc_d;

  logic [5:0]  id_ex_op_q, id_ex_op_d;
  itype_e      id_ex_typ_q, id_ex_typ_d;
  logic [4:0]  id_ex_dst_q, id_ex_dst_d;
  logic [31:0] id_ex_npc_q, id_ex_npc_d;
  logic [31:0] id_ex_a_q, id_ex_a_d;
  logic [31:0] id_ex_b_q, id_ex_b_d;
  logic [31:0] id_ex_imm_q, id_ex_imm_d;

  itype_e      ex_mem_typ_q, ex_mem_typ_d;
  logic [4:0]  ex_mem_dst_q, ex_mem_dst_d;
  logic [31:0] ex_mem_alu_q, ex_mem_alu_d;
  logic [31:0] ex_mem_b_q, ex_mem_b_d;
  logic        ex_mem_cond_q, ex_mem_cond_d;

  itype_e      mem_wb_typ_q, mem_wb_typ_d;
  logic [4:0]  mem_wb_dst_q, mem_wb_dst_d;
  logic [31:0] mem_wb_alu_q, mem_wb_alu_d;
  logic [31:0] mem_wb_lmd_q, mem_wb_lmd_d;

  logic        mem_we, rf_we;
  logic [9:0]  mem_wa;
  logic [4:0]  rf_wa;
  logic [31:0] mem_wd, rf_wd;

  logic [5:0]  dec_op;
  itype_e      dec_typ;
  logic [31:0] opb;

  assign dec_op = if_id_ir_q[31:26];
  assign opb = (id_ex_typ_q == T_RR) ? id_ex_b_q : id_ex_imm_q;

  always_comb begin
    dec_typ = T_NOP;
    case (dec_op)
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_SLT, OP_MUL:    dec_typ = T_RR;
      OP_ADDI, OP_SUBI, OP_SLTI: dec_typ = T_RM;
      OP_LW:                     dec_typ = T_LD;
      OP_SW:                     dec_typ = T_ST;
      OP_BNEQZ, OP_BEQZ:         dec_typ = T_BR;
      OP_HLT:                    dec_typ = T_HLT;
      default:                   dec_typ = T_NOP;
    endcase
  end

  always_comb begin
    pc_d = PC;
    halted_d = HALTED;
    phase_d = phase_q;
    taken_d = taken_q;
    if_id_ir_d = if_id_ir_q;
    if_id_npc_d = if_id_npc_q;
    id_ex_op_d = id_ex_op_q;
    id_ex_typ_d = id_ex_typ_q;
    id_ex_dst_d = id_ex_dst_q;
    id_ex_npc_d = id_ex_npc_q;
    id_ex_a_d = id_ex_a_q;
    id_ex_b_d = id_ex_b_q;
    id_ex_imm_d = id_ex_imm_q;
    ex_mem_typ_d = ex_mem_typ_q;
    ex_mem_dst_d = ex_mem_dst_q;
    ex_mem_alu_d = ex_mem_alu_q;
    ex_mem_b_d = ex_mem_b_q;
    ex_mem_cond_d = ex_mem_cond_q;
    mem_wb_typ_d = mem_wb_typ_q;
    mem_wb_dst_d = mem_wb_dst_q;
    mem_wb_alu_d = mem_wb_alu_q;
    mem_wb_lmd_d = mem_wb_lmd_q;
    mem_we = 1'b0;
    mem_wa = ex_mem_alu_q[9:0];
    mem_wd = ex_mem_b_q;
    rf_we = 1'b0;
    rf_wa = mem_wb_dst_q;
    rf_wd = mem_wb_alu_q;
    if (!HALTED) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        // a squashed branch (taken_q still set) must not redirect again
        if (ex_mem_typ_q == T_BR && ex_mem_cond_q && !taken_q) begin
          if_id_ir_d = mem[ex_mem_alu_q[9:0]];
          if_id_npc_d = ex_mem_alu_q + 32'd1;
          pc_d = ex_mem_alu_q + 32'd1;
          taken_d = 1'b1;
        end else if (dec_op != OP_HLT) begin
          if_id_ir_d = mem[PC[9:0]];
          if_id_npc_d = PC + 32'd1;
          pc_d = PC + 32'd1;
        end
        ex_mem_typ_d = id_ex_typ_q;
        ex_mem_dst_d = id_ex_dst_q;
        ex_mem_b_d = id_ex_b_q;
        ex_mem_cond_d = (id_ex_op_q == OP_BEQZ) ?
                        (id_ex_a_q == 32'd0) : (id_ex_a_q != 32'd0);
        case (id_ex_op_q)
          OP_ADD, OP_ADDI,
          OP_LW, OP_SW:      ex_mem_alu_d = id_ex_a_q + opb;
          OP_SUB, OP_SUBI:   ex_mem_alu_d = id_ex_a_q - opb;
          OP_AND:            ex_mem_alu_d = id_ex_a_q & opb;
          OP_OR:             ex_mem_alu_d = id_ex_a_q | opb;
          OP_SLT, OP_SLTI:   ex_mem_alu_d = {31'd0,
                               $signed(id_ex_a_q) < $signed(opb)};
          OP_MUL:            ex_mem_alu_d = id_ex_a_q * opb;
          OP_BNEQZ, OP_BEQZ: ex_mem_alu_d = id_ex_npc_q + id_ex_imm_q;
          default:           ex_mem_alu_d = 32'd0;
        endcase
        if (taken_q) begin
          taken_d = 1'b0;
        end else begin
          case (mem_wb_typ_q)
            T_RR, T_RM: rf_we = 1'b1;
            T_LD: begin
              rf_we = 1'b1;
              rf_wd = mem_wb_lmd_q;
            end
            T_HLT:   halted_d = 1'b1;
            default: rf_we = 1'b0;
          endcase
        end
      end else begin
        id_ex_op_d = dec_op;
        id_ex_typ_d = dec_typ;
        id_ex_dst_d = (dec_typ == T_RR) ?
                      if_id_ir_q[15:11] : if_id_ir_q[20:16];
        id_ex_npc_d = if_id_npc_q;
        id_ex_a_d = Reg[if_id_ir_q[25:21]];
        id_ex_b_d = Reg[if_id_ir_q[20:16]];
        id_ex_imm_d = {{16{if_id_ir_q[15]}}, if_id_ir_q[15:0]};
        mem_wb_typ_d = ex_mem_typ_q;
        mem_wb_dst_d = ex_mem_dst_q;
        mem_wb_alu_d = ex_mem_alu_q;
        if (ex_mem_typ_q == T_LD)
          mem_wb_lmd_d = mem[ex_mem_alu_q[9:0]];
        if (ex_mem_typ_q == T_ST && !taken_q)
          mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      PC <= 32'd0;
      HALTED <= 1'b0;
      phase_q <= 1'b0;
      taken_q <= 1'b0;
      if_id_ir_q <= 32'd0;
      if_id_npc_q <= 32'd0;
      id_ex_op_q <= 6'd0;
      id_ex_typ_q <= T_NOP;
      id_ex_dst_q <= 5'd0;
      id_ex_npc_q <= 32'd0;
      id_ex_a_q <= 32'd0;
      id_ex_b_q <= 32'd0;
      id_ex_imm_q <= 32'd0;
      ex_mem_typ_q <= T_NOP;
      ex_mem_dst_q <= 5'd0;
      ex_mem_alu_q <= 32'd0;
      ex_mem_b_q <= 32'd0;
      ex_mem_cond_q <= 1'b0;
      mem_wb_typ_q <= T_NOP;
      mem_wb_dst_q <= 5'd0;
      mem_wb_alu_q <= 32'd0;
      mem_wb_lmd_q <= 32'd0;
    end else begin
      PC <= pc_d;
      HALTED <= halted_d;
      phase_q <= phase_d;
      taken_q <= taken_d;
      if_id_ir_q <= if_id_ir_d;
      if_id_npc_q <= if_id_npc_d;
      id_ex_op_q <= id_ex_op_d;
      id_ex_typ_q <= id_ex_typ_d;
      id_ex_dst_q <= id_ex_dst_d;
      id_ex_npc_q <= id_ex_npc_d;
      id_ex_a_q <= id_ex_a_d;
      id_ex_b_q <= id_ex_b_d;
      id_ex_imm_q <= id_ex_imm_d;
      ex_mem_typ_q <= ex_mem_typ_d;
      ex_mem_dst_q <= ex_mem_dst_d;
      ex_mem_alu_q <= ex_mem_alu_d;
      ex_mem_b_q <= ex_mem_b_d;
      ex_mem_cond_q <= ex_mem_cond_d;
      mem_wb_typ_q <= mem_wb_typ_d;
      mem_wb_dst_q <= mem_wb_dst_d;
      mem_wb_alu_q <= mem_wb_alu_d;
      mem_wb_lmd_q <= mem_wb_lmd_d;
      if (mem_we) mem[mem_wa] <= mem_wd;
      if (rf_we) Reg[rf_wa] <= rf_wd;
    end
  end
endmodule

// File: tb/tb_mips32_pipe.sv
// tb_mips32_pipe: program-level bench for mips32_pipe.
// Expected state is queued per program and compared once it has run.
module tb_mips32_pipe;
  logic clk1 = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  int          kind_q[$];
  int          idx_q[$];
  logic [31:0] val_q[$];

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [31:0] HLT = {6'b111111, 26'd0};

  localparam int K_REG = 0;
  localparam int K_MEM = 1;
  localparam int K_PC  = 2;
  localparam int K_HLT = 3;

  mips32_pipe dut (.clk1(clk1), .rst(rst));

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] rr(
    input logic [5:0] op, input int rd, input int rs, input int rt);
    logic [31:0] w;
    w = {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
    return w;
  endfunction

  function automatic logic [31:0] ri(
    input logic [5:0] op, input int rt, input int rs, input int imm);
    logic [31:0] w;
    w = {op, rs[4:0], rt[4:0], imm[15:0]};
    return w;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_st(input string tag, input int kind,
                           input int idx, input logic [31:0] val);
    tag_q.push_back(tag);
    kind_q.push_back(kind);
    idx_q.push_back(idx);
    val_q.push_back(val);
  endtask

  task automatic drain();
    string t;
    int k;
    int i;
    logic [31:0] v;
    logic [31:0] got;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      k = kind_q.pop_front();
      i = idx_q.pop_front();
      v = val_q.pop_front();
      case (k)
        K_REG:   got = dut.Reg[i];
        K_MEM:   got = dut.mem[i];
        K_PC:    got = dut.PC;
        default: got = {31'd0, dut.HALTED};
      endcase
      check(t, got, v);
    end
  endtask

  task automatic begin_test();
    rst = 1'b1;
    @(posedge clk1);
    @(posedge clk1);
    @(negedge clk1);
    for (int i = 0; i < 1024; i++) dut.mem[i] = 32'd0;
    for (int r = 0; r < 32; r++) dut.Reg[r] = r;
  endtask

  task automatic go();
    @(negedge clk1);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk1);
      #1;
      if (dut.HALTED) break;
    end
    check("halt_wait", {31'd0, dut.HALTED}, 32'd1);
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    expect_st("rst_pc", K_PC, 0, 32'd0);
    expect_st("rst_halted", K_HLT, 0, 32'd0);
    drain();

    // factorial of 7, then freeze after HLT
    begin_test();
    dut.mem[0]  = ri(OP_ADDI, 0, 0, 200);
    dut.mem[1]  = ri(OP_LW, 1, 0, 200);
    dut.mem[2]  = rr(OP_ADD, 31, 31, 31);
    dut.mem[3]  = ri(OP_SUBI, 2, 1, 1);
    dut.mem[4]  = rr(OP_ADD, 16, 16, 16);
    dut.mem[5]  = rr(OP_MUL, 1, 1, 2);
    dut.mem[6]  = ri(OP_SUBI, 2, 2, 1);
    dut.mem[7]  = rr(OP_ADD, 31, 31, 31);
    dut.mem[8]  = ri(OP_BNEQZ, 0, 2, -4);
    dut.mem[9]  = ri(OP_SW, 1, 0, 0);
    dut.mem[10] = HLT;
    dut.mem[11] = ri(OP_ADDI, 20, 0, 77);
    dut.mem[200] = 32'd7;
    expect_st("fact_mem200", K_MEM, 200, 32'd5040);
    expect_st("fact_r1", K_REG, 1, 32'd5040);
    expect_st("fact_r2", K_REG, 2, 32'd0);
    expect_st("fact_r0", K_REG, 0, 32'd200);
    expect_st("fact_pc", K_PC, 0, 32'd11);
    go();
    run_to_halt(2000);
    drain();
    repeat (20) @(posedge clk1);
    #1;
    expect_st("frz_pc", K_PC, 0, 32'd11);
    expect_st("frz_mem200", K_MEM, 200, 32'd5040);
    expect_st("frz_r1", K_REG, 1, 32'd5040);
    expect_st("frz_r0", K_REG, 0, 32'd200);
    expect_st("frz_r20", K_REG, 20, 32'd20);
    expect_st("frz_halted", K_HLT, 0, 32'd1);
    drain();

    // distance-1 consumer sees the stale value, distance-2 the new one
    begin_test();
    dut.mem[0] = ri(OP_ADDI, 5, 0, 9);
    dut.mem[1] = rr(OP_ADD, 6, 5, 5);
    dut.mem[2] = rr(OP_ADD, 7, 5, 5);
    dut.mem[3] = HLT;
    expect_st("stale_r5", K_REG, 5, 32'd9);
    expect_st("stale_r6", K_REG, 6, 32'd10);
    expect_st("fresh_r7", K_REG, 7, 32'd18);
    go();
    run_to_halt(200);
    drain();

    // taken branch squashes exactly one slot
    begin_test();
    dut.mem[0] = ri(OP_BEQZ, 0, 0, 2);
    dut.mem[1] = ri(OP_SW, 7, 0, 100);
    dut.mem[2] = ri(OP_ADDI, 8, 0, 1);
    dut.mem[3] = ri(OP_ADDI, 9, 0, 3);
    dut.mem[4] = HLT;
    dut.mem[100] = 32'hDEAD_BEEF;
    expect_st("br_mem100", K_MEM, 100, 32'hDEAD_BEEF);
    expect_st("br_r8", K_REG, 8, 32'd8);
    expect_st("br_r9", K_REG, 9, 32'd3);
    expect_st("br_pc", K_PC, 0, 32'd5);
    go();
    run_to_halt(200);
    drain();

    // ALU coverage
    begin_test();
    dut.Reg[1] = -32'sd3;
    dut.Reg[2] = 32'd5;
    dut.mem[0]  = rr(OP_SUB, 3, 1, 2);
    dut.mem[1]  = rr(OP_AND, 4, 1, 2);
    dut.mem[2]  = rr(OP_OR, 5, 1, 2);
    dut.mem[3]  = rr(OP_SLT, 6, 1, 2);
    dut.mem[4]  = ri(OP_SLTI, 7, 2, -1);
    dut.mem[5]  = rr(OP_MUL, 8, 1, 2);
    dut.mem[6]  = rr(OP_SLT, 9, 2, 1);
    dut.mem[7]  = ri(OP_ADDI, 10, 1, -7);
    dut.mem[8]  = ri(OP_SUBI, 11, 2, 7);
    dut.mem[9]  = {6'b010000, 5'd0, 5'd12, 16'd99};
    dut.mem[10] = rr(OP_ADD, 13, 1, 2);
    dut.mem[11] = HLT;
    expect_st("alu_sub", K_REG, 3, 32'hFFFF_FFF8);
    expect_st("alu_and", K_REG, 4, 32'd5);
    expect_st("alu_or", K_REG, 5, 32'hFFFF_FFFD);
    expect_st("alu_slt", K_REG, 6, 32'd1);
    expect_st("alu_slti", K_REG, 7, 32'd0);
    expect_st("alu_mul", K_REG, 8, 32'hFFFF_FFF1);
    expect_st("alu_slt_rev", K_REG, 9, 32'd0);
    expect_st("alu_addi", K_REG, 10, 32'hFFFF_FFF6);
    expect_st("alu_subi", K_REG, 11, 32'hFFFF_FFFE);
    expect_st("alu_nop_rt", K_REG, 12, 32'd12);
    expect_st("alu_nop_r0", K_REG, 0, 32'd0);
    expect_st("alu_add", K_REG, 13, 32'd2);
    go();
    run_to_halt(300);
    drain();

    // reset mid-loop: edge 16 would be a WB of R20 and must not commit
    begin_test();
    dut.mem[0] = ri(OP_ADDI, 20, 20, 1);
    dut.mem[1] = ri(OP_BEQZ, 0, 0, -2);
    dut.mem[2] = ri(OP_SW, 20, 0, 300);
    dut.mem[3] = HLT;
    go();
    repeat (16) @(posedge clk1);
    @(negedge clk1);
    rst = 1'b1;
    @(posedge clk1);
    #1;
    expect_st("mrst_pc", K_PC, 0, 32'd0);
    expect_st("mrst_halted", K_HLT, 0, 32'd0);
    expect_st("mrst_r20", K_REG, 20, 32'd22);
    expect_st("mrst_mem300", K_MEM, 300, 32'd0);
    drain();
    @(negedge clk1);
    rst = 1'b0;
    repeat (5) @(posedge clk1);
    #1;
    expect_st("restart_r20", K_REG, 20, 32'd23);
    expect_st("restart_pc", K_PC, 0, 32'd3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
